// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit and the pipeline latches.
package pipe_ctrl_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  // All-zero word: sll $0,$0,0, loaded by a latch when it is flushed or bubbled.
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP      = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_HALTED    = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_unit_if.sv
// Bundle of the debug requests, hazard fields and pipeline-control outputs of pipeline_ctrl_unit.
interface pipeline_ctrl_unit_if #(
  parameter int REG_ADDR_W = pipe_ctrl_pkg::DEF_REG_ADDR_W,
  parameter int CNT_W      = 32
);
  logic                  run_req;
  logic                  step_req;
  logic                  halt_wb;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  idex_mem_read;
  logic                  idex_reg_write;
  logic [REG_ADDR_W-1:0] idex_rd;
  logic                  exmem_reg_write;
  logic [REG_ADDR_W-1:0] exmem_rd;
  logic                  branch_taken;

  logic                  pc_write;
  logic                  if_id_write;
  logic                  if_id_flush;
  logic                  id_ex_bubble;
  logic                  pipe_en;
  logic [2:0]            ctrl_state;
  logic [CNT_W-1:0]      cycle_cnt;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output run_req, step_req, halt_wb, id_rs, id_rt,
           idex_mem_read, idex_reg_write, idex_rd,
           exmem_reg_write, exmem_rd, branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
           pipe_en, ctrl_state, cycle_cnt, stall_cnt
  );

  modport slave (
    input  run_req, step_req, halt_wb, id_rs, id_rt,
           idex_mem_read, idex_reg_write, idex_rd,
           exmem_reg_write, exmem_rd, branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble,
           pipe_en, ctrl_state, cycle_cnt, stall_cnt
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational stall detection for the ID stage against instructions in EX and MEM.
// PCU_FWD_EN: EX forwarding exists, so only the load-use hazard stalls.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  idex_mem_read,
  input  logic                  idex_reg_write,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  output logic                  hz
);

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic src_match(input logic [REG_ADDR_W-1:0] rd,
                                     input logic [REG_ADDR_W-1:0] rs,
                                     input logic [REG_ADDR_W-1:0] rt);
    return (rd != '0) && ((rd == rs) || (rd == rt));
  endfunction

  logic load_use;
  assign load_use = idex_mem_read & src_match(idex_rd, id_rs, id_rt);

`ifdef PCU_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{idex_reg_write, exmem_reg_write, exmem_rd};
  assign hz = load_use;
`else
  assign hz = load_use
            | (idex_reg_write  & src_match(idex_rd,  id_rs, id_rt))
            | (exmem_reg_write & src_match(exmem_rd, id_rs, id_rt));
`endif

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Run/step/halt sequencer for the 5-stage pipeline: latch enables, bubbles, flushes, counters.
// PCU_FWD_EN selects the forwarding-aware hazard rule inside hazard_detect.
module pipeline_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_ctrl_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_state_e      state_q, state_d;
  logic             hz;
  logic             active;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .id_rs           (bus.id_rs),
    .id_rt           (bus.id_rt),
    .idex_mem_read   (bus.idex_mem_read),
    .idex_reg_write  (bus.idex_reg_write),
    .idex_rd         (bus.idex_rd),
    .exmem_reg_write (bus.exmem_reg_write),
    .exmem_rd        (bus.exmem_rd),
    .hz              (hz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Outputs depend only on the current state and hazard inputs, so a stall or
  // flush takes effect in the same cycle it is detected.
  always_comb begin
    state_d          = state_q;
    active           = 1'b0;
    bus.pc_write     = 1'b0;
    bus.if_id_write  = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_bubble = 1'b0;
    bus.pipe_en      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_STEP_WAIT: begin
        if (bus.run_req)       state_d = ST_RUN;
        else if (bus.step_req) state_d = ST_STEP;
      end
      ST_RUN: begin
        active = 1'b1;
        if (bus.halt_wb) state_d = ST_HALTED;
      end
      ST_STEP: begin
        active  = 1'b1;
        state_d = bus.halt_wb ? ST_HALTED : ST_STEP_WAIT;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase

    // A stall holds PC and IF/ID and drops any pending flush; the branch
    // resolves again once the stall clears.
    if (active) begin
      bus.pipe_en      = 1'b1;
      bus.pc_write     = ~hz;
      bus.if_id_write  = ~hz;
      bus.id_ex_bubble = hz;
      bus.if_id_flush  = ~hz & bus.branch_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (active) begin
      cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
      if (hz) stall_cnt_q <= stall_cnt_q + CNT_ONE;
    end
  end

  assign bus.ctrl_state = state_q;
  assign bus.cycle_cnt  = cycle_cnt_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: doc/pipeline_ctrl_unit.md
Name: pipeline_ctrl_unit

Overview:
- Central sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline.
- Generates per-stage write enables, bubble and flush controls, so it is the only block that freezes or advances the pipeline latches.
- Detects data hazards and taken branches, and runs a run/step/halt FSM driven by the debug unit.
- Keeps cycle and stall counters for debug readout.

Parameters:
REG_ADDR_W, 5, register-file address width
CNT_W, 32, width of cycle/stall counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
run_req  in  1  pulse: free-run the pipeline
step_req  in  1  pulse: advance the pipeline exactly one cycle
halt_wb  in  1  HALT instruction is valid in the WB stage
id_rs  in  REG_ADDR_W  rs of the instruction in ID
id_rt  in  REG_ADDR_W  rt of the instruction in ID
idex_mem_read  in  1  instruction in EX is a load
idex_reg_write  in  1  instruction in EX writes a register
idex_rd  in  REG_ADDR_W  destination register of the instruction in EX
exmem_reg_write  in  1  instruction in MEM writes a register
exmem_rd  in  REG_ADDR_W  destination register of the instruction in MEM
branch_taken  in  1  branch/jump resolved taken in ID
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID latch enable
if_id_flush  out  1  IF/ID latch loads NOP
id_ex_bubble  out  1  ID/EX latch loads NOP
pipe_en  out  1  EX/MEM and MEM/WB latch enable
ctrl_state  out  3  current FSM state encoding
cycle_cnt  out  CNT_W  cycles with pipe_en=1 since reset
stall_cnt  out  CNT_W  cycles with a hazard stall since reset

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - All enables and flush/bubble outputs are 0.
  - ctrl_state = IDLE.
  - Both counters are 0.
- FSM states: IDLE=0, RUN=1, STEP=2, STEP_WAIT=3, HALTED=4.
- Transitions:
  - IDLE: run_req -> RUN; step_req -> STEP. If both are high, run_req wins.
  - RUN: halt_wb -> HALTED. step_req is ignored.
  - STEP: lasts exactly one cycle with the pipeline enabled, then -> STEP_WAIT, or -> HALTED if halt_wb is high that cycle.
  - STEP_WAIT: step_req -> STEP; run_req -> RUN; run_req wins if both are high.
  - HALTED: terminal; only rst_n exits. All requests are ignored.
- Active cycle: any cycle in state RUN or STEP. Enables are combinational from state and hazard inputs, with zero-cycle latency.
- Hazard stall condition hz:
  - Load-use: idex_mem_read & (idex_rd != 0) & (idex_rd == id_rs | idex_rd == id_rt).
  - Without PCU_FWD_EN, hz also includes the RAW terms listed under Optional Feature.
- Outputs during an active cycle:
  - pipe_en = 1.
  - hz = 1: pc_write = 0, if_id_write = 0, id_ex_bubble = 1, if_id_flush = 0, stall_cnt += 1.
  - hz = 0: pc_write = 1, if_id_write = 1, id_ex_bubble = 0, and if_id_flush = branch_taken.
  - hz and branch_taken together: hz has priority and the flush is suppressed. The branch re-resolves on the next cycle.
- Inactive cycle (IDLE, STEP_WAIT, HALTED): all outputs are 0 and no counter changes. The pipeline is fully frozen.
- halt_wb in RUN: that cycle is still active (the WB write completes); the next cycle is HALTED.
- cycle_cnt increments on every active cycle. Both counters wrap modulo 2^CNT_W with no saturation.
- Reset asserted mid-RUN: outputs drop to 0 immediately (asynchronous); state returns to IDLE.

Optional Feature:
- Macro: PCU_FWD_EN.
- Defined: the EX stage has forwarding, so hz is the load-use term only.
- Undefined: no forwarding. hz additionally includes:
  - idex_reg_write & (idex_rd != 0) & (idex_rd matches id_rs or id_rt), and
  - exmem_reg_write & (exmem_rd != 0) & (exmem_rd matches id_rs or id_rt).
- The port list is identical in both builds.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum typedef (IDLE..HALTED, 3 bits);
  - REG_ADDR_W default;
  - the NOP encoding constant, also used by the latches.
- Sub-module: hazard_detect. Purely combinational; takes the ID/EX/MEM register fields and outputs hz. It holds the PCU_FWD_EN ifdef.
- The FSM and counters stay in pipeline_ctrl_unit.

Test Plan:
- Reset then run_req pulse:
  - ctrl_state goes 0 -> 1.
  - pc_write, if_id_write and pipe_en are 1 from the next cycle.
  - After 10 cycles, cycle_cnt = 10.
- Load-use in RUN (idex_mem_read=1, idex_rd=5, id_rs=5):
  - pc_write = 0, if_id_write = 0, id_ex_bubble = 1, pipe_en = 1.
  - stall_cnt = 1.
  - With idex_rd = 0, no stall.
- branch_taken=1 with no hazard: if_id_flush = 1 for exactly that cycle. The same stimulus with load-use hz also active gives if_id_flush = 0 and id_ex_bubble = 1.
- Step mode: step_req from IDLE.
  - Exactly one cycle with pipe_en = 1, then STEP_WAIT with all outputs 0 for 5 cycles.
  - A second step_req gives one more active cycle; cycle_cnt = 2.
- halt_wb in RUN:
  - That cycle has pipe_en = 1; the next cycle is ctrl_state = 4 with all outputs 0.
  - run_req and step_req are then ignored.
  - rst_n low mid-HALTED returns to IDLE with counters 0.
- Without PCU_FWD_EN: idex_reg_write=1, idex_rd=3, id_rt=3, idex_mem_read=0 -> stall (id_ex_bubble = 1). With PCU_FWD_EN defined -> no stall.
